// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port synchronous RAM.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed data-first priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req_i,
  input  logic [ADDR_W-1:0]     inst_addr_i,
  output logic                  inst_ack_o,
  output logic [DATA_W-1:0]     inst_rdata_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [ADDR_W-1:0]     data_addr_i,
  input  logic [DATA_W-1:0]     data_wdata_i,
  input  logic [DATA_W/8-1:0]   data_sel_i,
  output logic                  data_ack_o,
  output logic [DATA_W-1:0]     data_rdata_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W-1:0]     ram_wdata_o,
  output logic [DATA_W/8-1:0]   ram_sel_o,
  input  logic [DATA_W-1:0]     ram_rdata_i,
  output logic                  stall_o
);

  typedef enum logic [2:0] {IDLE, CMD_I, CMD_D, RESP_I, RESP_D} state_t;

  state_t state, state_nxt;
  logic   elig_i, elig_d;
  logic   grant_i, grant_d;

`ifdef ARB_RR_EN
  logic last_d;

  // 1 means the data port won the most recent grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (grant_d) begin
      last_d <= 1'b1;
    end else if (grant_i) begin
      last_d <= 1'b0;
    end
  end
`endif

  // The port being acked this cycle sits out one arbitration round
  always_comb begin
    elig_i  = inst_req_i && (state != RESP_I);
    elig_d  = data_req_i && (state != RESP_D);
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE || state == RESP_I || state == RESP_D) begin
`ifdef ARB_RR_EN
      if (elig_i && elig_d) begin
        grant_d = !last_d;
        grant_i = last_d;
      end else begin
        grant_d = elig_d;
        grant_i = elig_i;
      end
`else
      grant_d = elig_d;
      grant_i = elig_i && !elig_d;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP_I, RESP_D: begin
        if (grant_d) begin
          state_nxt = CMD_D;
        end else if (grant_i) begin
          state_nxt = CMD_I;
        end else begin
          state_nxt = IDLE;
        end
      end
      CMD_I:   state_nxt = RESP_I;
      CMD_D:   state_nxt = RESP_D;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM command is captured on the grant edge and strobed for exactly one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_sel_o   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        ram_ce_o    <= 1'b1;
        ram_we_o    <= data_we_i;
        ram_addr_o  <= data_addr_i;
        ram_wdata_o <= data_wdata_i;
        ram_sel_o   <= data_sel_i;
      end else if (grant_i) begin
        ram_ce_o    <= 1'b1;
        ram_we_o    <= 1'b0;
        ram_addr_o  <= inst_addr_i;
        ram_wdata_o <= '0;
        ram_sel_o   <= '1;
      end else begin
        ram_ce_o    <= 1'b0;
        ram_we_o    <= 1'b0;
      end
    end
  end

  assign inst_ack_o   = (state == RESP_I);
  assign data_ack_o   = (state == RESP_D);
  assign inst_rdata_o = inst_ack_o ? ram_rdata_i : '0;
  assign data_rdata_o = data_ack_o ? ram_rdata_i : '0;
  assign stall_o      = (inst_req_i && !inst_ack_o) || (data_req_i && !data_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural sync RAM, reference memory and
// per-port scoreboards of expected read data.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_ack_o;
  logic [31:0] inst_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_sel_i;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_rdata;
  logic        stall_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram_mem [0:255];
  logic [31:0] ref_mem [0:255];
  bit          ram_loaded = 1'b0;
  logic [31:0] inst_q [$];
  logic [31:0] data_q [$];
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_ack_o(inst_ack_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_sel_i(data_sel_i),
    .data_ack_o(data_ack_o), .data_rdata_o(data_rdata_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_sel_o(ram_sel_o),
    .ram_rdata_i(ram_rdata), .stall_o(stall_o)
  );

  function automatic logic [31:0] init_word(int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 4) return 32'h3408_1234;
    if (i == 'h40) return 32'h1111_1111;
    return {8'hA5, b, ~b, 8'h5A ^ b};
  endfunction

  // Single-port synchronous RAM: read data appears the cycle after ce is sampled
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (ram_ce_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel_o[b]) ram_mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
      ram_rdata <= ram_mem[ram_addr_o[9:2]];
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_req_i = 1'b1;
    inst_addr_i = 32'h10;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o, inst_ack_o, data_ack_o,
         inst_rdata_o, data_rdata_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: ce=%b we=%b addr=%h sel=%h iack=%b dack=%b want all 0",
               ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, inst_ack_o, data_ack_o);
    end
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_stall_req: got %b want 1", stall_o);
    end
    inst_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_stall_idle: got %b want 0", stall_o);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ram_ce_o, inst_ack_o, data_ack_o} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_release: ce/iack/dack=%b want 000", {ram_ce_o, inst_ack_o, data_ack_o});
    end
  endtask

  task automatic test_single_fetch();
    inst_addr_i = 32'h0000_0010;
    inst_req_i  = 1'b1;
    inst_q.push_back(32'h3408_1234);
    @(negedge clk);
    vectors++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, inst_ack_o, stall_o} !== {2'b10, 32'h10, 4'hF, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL fetch_cmd: ce=%b we=%b addr=%h sel=%h iack=%b stall=%b want 1 0 10 f 0 1",
               ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, inst_ack_o, stall_o);
    end
    @(negedge clk);
    vectors++;
    if ({inst_ack_o, data_ack_o, ram_ce_o, stall_o} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL fetch_ack: iack=%b dack=%b ce=%b stall=%b want 1 0 0 0",
               inst_ack_o, data_ack_o, ram_ce_o, stall_o);
    end
    if (inst_ack_o) begin
      exp_w = inst_q.pop_front();
      vectors++;
      if (inst_rdata_o !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL fetch_rdata: got %h want %h", inst_rdata_o, exp_w);
      end
    end
    inst_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({inst_ack_o, inst_rdata_o, stall_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL fetch_after: iack=%b rdata=%h stall=%b want 0", inst_ack_o, inst_rdata_o, stall_o);
    end
  endtask

  task automatic test_store();
    data_we_i    = 1'b1;
    data_addr_i  = 32'h100;
    data_wdata_i = 32'hDEAD_BEEF;
    data_sel_i   = 4'b0011;
    data_req_i   = 1'b1;
    for (int b = 0; b < 4; b++)
      if (data_sel_i[b]) ref_mem[8'h40][8*b +: 8] = data_wdata_i[8*b +: 8];
    @(negedge clk);
    vectors++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o} !== {2'b11, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
      miscompares++;
      $display("[TB] FAIL store_cmd: ce=%b we=%b addr=%h wdata=%h sel=%b want 1 1 100 deadbeef 0011",
               ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o);
    end
    @(negedge clk);
    vectors++;
    if ({data_ack_o, inst_ack_o, ram_ce_o, ram_we_o} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL store_ack: dack=%b iack=%b ce=%b we=%b want 1 0 0 0",
               data_ack_o, inst_ack_o, ram_ce_o, ram_we_o);
    end
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    @(negedge clk);
    vectors++;
    if ({data_ack_o, inst_ack_o, ram_ce_o} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL store_after: dack=%b iack=%b ce=%b want 000", data_ack_o, inst_ack_o, ram_ce_o);
    end
  endtask

  task automatic test_load_after_store();
    int ack_k;
    ack_k = -1;
    data_addr_i = 32'h100;
    data_sel_i  = 4'hF;
    data_req_i  = 1'b1;
    data_q.push_back(ref_mem[8'h40]);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (data_ack_o) begin
        ack_k = k;
        exp_w = data_q.pop_front();
        vectors++;
        if (data_rdata_o !== exp_w) begin
          miscompares++;
          $display("[TB] FAIL load_merge_rdata: got %h want %h", data_rdata_o, exp_w);
        end
        data_req_i = 1'b0;
      end
    end
    data_req_i = 1'b0;
    vectors++;
    if (ack_k != 2) begin
      miscompares++;
      $display("[TB] FAIL load_latency: ack at cycle %0d want 2", ack_k);
    end
  endtask

  task automatic test_collision();
    int d_k, i_k;
    d_k = -1;
    i_k = -1;
    data_addr_i = 32'h20;
    inst_addr_i = 32'h30;
    data_req_i  = 1'b1;
    inst_req_i  = 1'b1;
    data_q.push_back(ref_mem[8]);
    inst_q.push_back(ref_mem[12]);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if (stall_o !== (k < 4)) begin
        miscompares++;
        $display("[TB] FAIL collide_stall_c%0d: got %b want %b", k, stall_o, (k < 4));
      end
      if (k == 1 || k == 3) begin
        vectors++;
        if ({ram_ce_o, ram_we_o, ram_addr_o} !== {2'b10, (k == 1) ? 32'h20 : 32'h30}) begin
          miscompares++;
          $display("[TB] FAIL collide_cmd_c%0d: ce=%b we=%b addr=%h want 1 0 %h",
                   k, ram_ce_o, ram_we_o, ram_addr_o, (k == 1) ? 32'h20 : 32'h30);
        end
      end
      if (data_ack_o) begin
        d_k = k;
        exp_w = data_q.pop_front();
        vectors++;
        if (data_rdata_o !== exp_w) begin
          miscompares++;
          $display("[TB] FAIL collide_drdata: got %h want %h", data_rdata_o, exp_w);
        end
        data_req_i = 1'b0;
      end
      if (inst_ack_o) begin
        i_k = k;
        exp_w = inst_q.pop_front();
        vectors++;
        if (inst_rdata_o !== exp_w) begin
          miscompares++;
          $display("[TB] FAIL collide_irdata: got %h want %h", inst_rdata_o, exp_w);
        end
        inst_req_i = 1'b0;
      end
    end
    data_req_i = 1'b0;
    inst_req_i = 1'b0;
    vectors++;
    if (d_k != 2 || i_k != 4) begin
      miscompares++;
      $display("[TB] FAIL collide_order: data ack %0d inst ack %0d want 2 and 4", d_k, i_k);
    end
  endtask

  task automatic test_back_to_back();
    int issued, acks, ack_k;
    bit exp_d;
    issued = 2;
    acks   = 0;
    data_addr_i = 32'h200;
    inst_addr_i = 32'h300;
    data_req_i  = 1'b1;
    inst_req_i  = 1'b1;
    data_q.push_back(ref_mem[data_addr_i[9:2]]);
    inst_q.push_back(ref_mem[inst_addr_i[9:2]]);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (data_ack_o || inst_ack_o) begin
        acks++;
        exp_d = (acks % 2) == 1;
        vectors++;
        if ({data_ack_o, inst_ack_o} !== {exp_d, !exp_d} || k != 2 * acks) begin
          miscompares++;
          $display("[TB] FAIL b2b_grant_%0d: dack=%b iack=%b cycle %0d want dack=%b cycle %0d",
                   acks, data_ack_o, inst_ack_o, k, exp_d, 2 * acks);
        end
        if (data_ack_o) begin
          exp_w = data_q.pop_front();
          vectors++;
          if (data_rdata_o !== exp_w) begin
            miscompares++;
            $display("[TB] FAIL b2b_drdata_%0d: got %h want %h", acks, data_rdata_o, exp_w);
          end
          if (issued < 8) begin
            data_addr_i = data_addr_i + 32'h4;
            data_q.push_back(ref_mem[data_addr_i[9:2]]);
            issued++;
          end else data_req_i = 1'b0;
        end
        if (inst_ack_o) begin
          exp_w = inst_q.pop_front();
          vectors++;
          if (inst_rdata_o !== exp_w) begin
            miscompares++;
            $display("[TB] FAIL b2b_irdata_%0d: got %h want %h", acks, inst_rdata_o, exp_w);
          end
          if (issued < 8) begin
            inst_addr_i = inst_addr_i + 32'h4;
            inst_q.push_back(ref_mem[inst_addr_i[9:2]]);
            issued++;
          end else inst_req_i = 1'b0;
        end
      end
      if (acks == 8) break;
    end
    ack_k = acks;
    data_req_i = 1'b0;
    inst_req_i = 1'b0;
    vectors++;
    if (ack_k != 8) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d acks want 8", ack_k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    data_addr_i = 32'h44;
    data_we_i   = 1'b0;
    data_req_i  = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ram_ce_o, ram_addr_o} !== {1'b1, 32'h44}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_cmd: ce=%b addr=%h want 1 44", ram_ce_o, ram_addr_o);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o, inst_ack_o, data_ack_o,
         inst_rdata_o, data_rdata_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_abort: ce=%b addr=%h dack=%b drdata=%h want all 0",
               ram_ce_o, ram_addr_o, data_ack_o, data_rdata_o);
    end
    rst = 1'b1;
    data_q.push_back(ref_mem[8'h11]);
    @(negedge clk);
    vectors++;
    if ({ram_ce_o, ram_addr_o, data_ack_o} !== {1'b1, 32'h44, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_reissue: ce=%b addr=%h dack=%b want 1 44 0", ram_ce_o, ram_addr_o, data_ack_o);
    end
    @(negedge clk);
    vectors++;
    if (data_ack_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_ack: got %b want 1", data_ack_o);
    end else begin
      exp_w = data_q.pop_front();
      vectors++;
      if (data_rdata_o !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL rstmid_rdata: got %h want %h", data_rdata_o, exp_w);
      end
    end
    data_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_withdrawal();
    data_addr_i = 32'h48;
    data_req_i  = 1'b1;
    data_q.push_back(ref_mem[8'h12]);
    @(negedge clk);
    inst_addr_i = 32'h50;
    inst_req_i  = 1'b1;
    @(negedge clk);
    inst_req_i = 1'b0;
    vectors++;
    if (data_ack_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL withdraw_dack: got %b want 1", data_ack_o);
    end else begin
      exp_w = data_q.pop_front();
      vectors++;
      if (data_rdata_o !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL withdraw_rdata: got %h want %h", data_rdata_o, exp_w);
      end
    end
    data_req_i = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      vectors++;
      if ({ram_ce_o, inst_ack_o, data_ack_o} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL withdraw_quiet_c%0d: ce/iack/dack=%b want 000", k, {ram_ce_o, inst_ack_o, data_ack_o});
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    inst_req_i   = 1'b0;
    inst_addr_i  = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    data_sel_i   = 4'hF;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    $display("[TB] mem_arbiter bench start");
    test_reset();
    test_single_fetch();
    test_store();
    test_load_after_store();
    pulse_reset();
    test_collision();
    pulse_reset();
    test_back_to_back();
    test_reset_mid();
    test_withdrawal();
    vectors++;
    if (inst_q.size() != 0 || data_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d fetch and %0d data results outstanding, want 0",
               inst_q.size(), data_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address width of both requesters and the RAM port.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data width, a multiple of 8.
REQ-003 clk  in  1  single system clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 inst_req_i  in  1  instruction-fetch request, held high until inst_ack_o.
REQ-006 inst_addr_i  in  ADDR_W  fetch address, stable while inst_req_i is high.
REQ-007 inst_ack_o  out  1  one-cycle completion pulse for the fetch.
REQ-008 inst_rdata_o  out  DATA_W  fetch data, valid only while inst_ack_o is high.
REQ-009 data_req_i  in  1  load/store request, held high until data_ack_o.
REQ-010 data_we_i  in  1  1 = store, 0 = load.
REQ-011 data_addr_i / data_wdata_i / data_sel_i  in  ADDR_W / DATA_W / DATA_W/8  load/store address, store data and byte enables, stable while data_req_i is high.
REQ-012 data_ack_o  out  1  one-cycle completion pulse for the load/store.
REQ-013 data_rdata_o  out  DATA_W  load data, valid only while data_ack_o is high.
REQ-014 ram_ce_o / ram_we_o / ram_addr_o / ram_wdata_o / ram_sel_o  out  1 / 1 / ADDR_W / DATA_W / DATA_W/8  registered command to a single-port synchronous RAM.
REQ-015 ram_rdata_i  in  DATA_W  RAM read data, valid the cycle after the RAM samples ram_ce_o=1.
REQ-016 stall_o  out  1  pipeline stall request: (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o).

Function
REQ-017 The FSM SHALL have states IDLE, CMD_I, CMD_D, RESP_I and RESP_D.
REQ-018 In IDLE, at each edge, the FSM SHALL arbitrate pending requests (REQ-024) and move to CMD_I or CMD_D; with no request it SHALL stay in IDLE.
REQ-019 On entering CMD_x, the block SHALL register the granted port's command into ram_*_o with ram_ce_o=1.
- For fetch: ram_we_o=0 and ram_sel_o all-ones.
REQ-020 CMD_x SHALL last exactly one cycle and then go to RESP_x; ram_ce_o and ram_we_o SHALL return to 0 on that edge.
REQ-021 In RESP_x, ack_x SHALL be 1 and rdata_x SHALL equal ram_rdata_i (combinational); in all other states ack and rdata SHALL be 0.
- For a store, data_rdata_o is don't-care but driven from ram_rdata_i.
REQ-022 Latency: from the edge at which the request is sampled to the ack cycle is exactly 2 cycles, and the ack lasts exactly 1 cycle.
REQ-023 From RESP_x, the FSM SHALL arbitrate as in IDLE, but the port being acked SHALL be ineligible that cycle; back-to-back alternating accesses therefore take 2 cycles each.
REQ-024 Fixed priority (macro absent): when both ports request, data wins and fetch waits.
REQ-025 At most one RAM command SHALL be outstanding; a port's second request SHALL NOT be granted before its first ack.
REQ-026 A request that drops before its grant SHALL be discarded without any RAM access; one that drops after its grant SHALL still complete, and its ack SHALL be ignored.

Reset
REQ-027 While rst=0 at a rising edge, the FSM SHALL go to IDLE and all registered outputs SHALL go to 0.
- Combinational outputs then read 0: acks 0, rdata 0, stall_o follows the requests.
REQ-028 Reset asserted in CMD_x or RESP_x SHALL abort the access: no ack, and ram_ce_o=0 from the next cycle.
- A store already sampled by the RAM is not rolled back.

Configuration
REQ-029 With macro ARB_RR_EN defined, arbitration SHALL be round-robin using a 1-bit last-grant register (reset value: fetch).
- When both ports request, the port not granted last wins.
- When only one port requests, it is granted and the register is updated.
REQ-030 Without ARB_RR_EN, the last-grant register SHALL NOT exist and REQ-024 applies.

Verification
REQ-031 Single fetch: inst_req_i=1, addr=0x0000_0010, RAM returns 0x3408_1234 -> ram_ce_o=1 with addr 0x10 one cycle after sampling, inst_ack_o=1 with inst_rdata_o=0x3408_1234 one cycle later, stall_o=0 after the request drops.
REQ-032 Store: data_we_i=1, addr=0x100, wdata=0xDEAD_BEEF, sel=4'b0011 -> one cycle with ram_we_o=1 carrying those exact values, then data_ack_o pulse, inst_ack_o stays 0.
REQ-033 Collision, fixed priority: both requests raised on the same edge -> CMD_D first, data_ack_o at +2 cycles, inst_ack_o at +4 cycles, stall_o high until +4.
REQ-034 Collision with ARB_RR_EN: both ports held high for 8 accesses -> grants strictly alternate D,I,D,I... (last-grant resets to fetch), 2 cycles per access.
REQ-035 Reset mid-operation: rst=0 in the CMD_D cycle -> no data_ack_o, all outputs 0 next cycle; the re-issued request after rst=1 completes normally with 2-cycle latency.
REQ-036 Withdrawal: inst_req_i pulsed for one cycle while data holds the grant -> no RAM fetch issued, inst_ack_o never asserted.
